// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes and default bit timing.
// Intended for reuse by the receive path as well.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 50 MHz / 115200 baud
  localparam int UART_CLK_CNT_DEFAULT = 434;

  // Even: XOR of the data bits; odd: its inverse.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_tick on the last clock of every bit while enabled.
// The counter is held at zero whenever the enable is low.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int UART_CLK_CNT = UART_CLK_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (UART_CLK_CNT > 2) ? $clog2(UART_CLK_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(UART_CLK_CNT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last   = (r_cnt == LAST);
  assign bit_tick = en && w_last;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, 8 data bits LSB first with optional
// parity and one or two stop bits; the serial pin is a registered output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int UART_CLK_CNT = UART_CLK_CNT_DEFAULT,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_tx_pin
);

  uart_tx_state_t r_state;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic [2:0]     r_bit_idx;
  logic           r_stop_idx;
  logic           r_pin;
  logic           r_ready;
  logic           r_busy;

  logic           w_tick;
  logic           w_baud_en;
  logic           w_handshake;

  assign w_baud_en   = (r_state != IDLE);
  assign w_handshake = tx_valid && r_ready;

  assign tx_ready    = r_ready;
  assign tx_busy     = r_busy;
  assign uart_tx_pin = r_pin;

  uart_baud_gen #(
    .UART_CLK_CNT(UART_CLK_CNT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (w_baud_en),
    .bit_tick(w_tick)
  );

  // The pin is loaded one bit ahead: each tick registers the next bit's level,
  // and the shift register moves right so bit 1 is always the next data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_pin      <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pin <= 1'b1;
          if (w_handshake) begin
            r_shift  <= tx_data;
            r_parity <= calc_parity(tx_data, PARITY_MODE);
            r_state  <= START;
            r_pin    <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_pin     <= r_shift[0];
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              if (PARITY_MODE != PARITY_NONE) begin
                r_state <= PARITY;
                r_pin   <= r_parity;
              end else begin
                r_state    <= STOP;
                r_stop_idx <= 1'b0;
                r_pin      <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_pin     <= r_shift[1];
              r_shift   <= {1'b1, r_shift[7:1]};
            end
          end
        end

        PARITY: begin
          if (w_tick) begin
            r_state    <= STOP;
            r_stop_idx <= 1'b0;
            r_pin      <= 1'b1;
          end
        end

        STOP: begin
          r_pin <= 1'b1;
          if (w_tick) begin
            if (r_stop_idx == 1'(STOP_BITS - 1)) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_pin   <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three parameter sets run side by side, each with
// a driver pushing accepted bytes and a monitor checking every cycle of each frame.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [NCFG-1:0] done;

  task automatic check(input string name, input int cfg,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cfg%0d actual=0x%0h required=0x%0h", name, cfg, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int cfg);
    checks++;
    failures++;
    $display("FAIL %s cfg%0d actual=timeout required=event", name, cfg);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N     = (g == 0) ? 4 : ((g == 1) ? 5 : 3);
    localparam int PM    = (g == 0) ? PARITY_NONE : ((g == 1) ? PARITY_ODD : PARITY_EVEN);
    localparam int SB    = (g == 1) ? 2 : 1;
    localparam int P     = (PM != PARITY_NONE) ? 1 : 0;
    localparam int NBITS = 1 + 8 + P + SB;
    localparam int F     = NBITS * N;

    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       pin;
    logic [7:0] exp_q[$];
    logic       drv_done;
    logic       mon_done;

    assign done[g] = mon_done;

    uart_tx #(
      .UART_CLK_CNT(N),
      .PARITY_MODE (PM),
      .STOP_BITS   (SB)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .uart_tx_pin(pin)
    );

    // Line level of frame bit i: start, data LSB first, parity, stop(s).
    function automatic logic ref_bit(input logic [7:0] d, input int i);
      int ones;
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (P == 1 && i == 9) begin
        ones = $countones(d);
        return (PM == PARITY_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0);
      end
      return 1'b1;
    endfunction

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
    endtask

    // Hold valid with junk data until ready, then present d for the handshake.
    task automatic send(input logic [7:0] d);
      bit ok;
      ok = 0;
      for (int k = 0; k < 4 * F && !ok; k++) begin
        @(posedge clk); #1;
        tx_valid = 1'b1;
        if (tx_ready) begin
          tx_data = d;
          exp_q.push_back(d);
          ok = 1;
        end else begin
          tx_data = 8'($urandom);
        end
      end
      if (!ok) fail_now("send_ready", g);
    endtask

    initial begin : driver
      drv_done = 1'b0;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(3);

      if (g == 0) send(8'h55);
      if (g == 1) send(8'h00);
      if (g == 2) begin
        send(8'h07);
        idle(2);
        send(8'h03);
      end
      idle(2);
      send(8'hA5);
      send(8'h3C);
      idle(3);

      for (int i = 0; i < 40; i++) begin
        send(8'($urandom));
        idle(int'($urandom_range(0, 3)));
      end
      idle(2);

      // Abort a frame during data bit 3, then stay quiet for a while.
      send(8'($urandom));
      @(posedge clk); #1;
      tx_valid = 1'b0;
      repeat (4 * N + 1) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(4 * N);

      for (int i = 0; i < 6; i++) begin
        send(8'($urandom));
        idle(int'($urandom_range(0, 2)));
      end
      idle(1);
      drv_done = 1'b1;
    end

    // Called with frame cycle 0 (start bit seen low) already sampled.
    task automatic frame_check(output bit exp_start);
      logic [7:0] d;
      logic [2:0] act, req, bad_act, bad_req;
      bit bad, aborted, quiet_ok;
      int badc;
      exp_start = 0;
      bad_act   = '0;
      bad_req   = '0;
      badc      = 0;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame cfg%0d actual=start required=idle", g);
        for (int k = 0; k < F && pin == 1'b0; k++) @(negedge clk);
        return;
      end
      d       = exp_q.pop_front();
      bad     = 0;
      aborted = 0;
      for (int c = 0; c < F; c++) begin
        if (c > 0) @(negedge clk);
        if (rst) begin
          aborted = 1;
          break;
        end
        act = {pin, tx_busy, tx_ready};
        req = {ref_bit(d, c / N), 1'b1, 1'b0};
        if (!bad && act !== req) begin
          bad     = 1;
          badc    = c;
          bad_act = act;
          bad_req = req;
        end
      end
      if (aborted) begin
        @(negedge clk);
        check("reset_abort_pin_ready_busy", g, {29'd0, pin, tx_ready, tx_busy}, 32'b110);
        quiet_ok = 1;
        for (int k = 0; k < 3 * N; k++) begin
          @(negedge clk);
          if (pin !== 1'b1 || tx_busy !== 1'b0) quiet_ok = 0;
        end
        check("reset_quiet_line", g, {31'd0, quiet_ok}, 32'd1);
        return;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL frame cfg%0d byte=0x%02h cycle=%0d actual{pin,busy,ready}=%b required=%b",
                 g, d, badc, bad_act, bad_req);
      end
      @(negedge clk);
      check("frame_end_pin_ready_busy", g, {29'd0, pin, tx_ready, tx_busy}, 32'b110);
      exp_start = (tx_valid === 1'b1);
    endtask

    initial begin : monitor
      int  idle_cnt;
      bit  expect_start;
      bit  nxt;
      mon_done = 1'b0;
      @(negedge clk);
      while (rst !== 1'b0) @(negedge clk);
      check("reset_state", g, {29'd0, pin, tx_ready, tx_busy}, 32'b110);
      idle_cnt     = 0;
      expect_start = 0;
      while (!mon_done) begin
        @(negedge clk);
        if (expect_start) check("back_to_back_start", g, {31'd0, pin}, 32'd0);
        expect_start = 0;
        if (pin === 1'b0 && !rst) begin
          idle_cnt = 0;
          frame_check(nxt);
          expect_start = nxt;
        end else begin
          idle_cnt++;
          if (drv_done && exp_q.size() == 0 && idle_cnt > 2) begin
            mon_done = 1'b1;
          end else if (idle_cnt > 8 * F) begin
            fail_now("start_timeout", g);
            mon_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (done !== '1 && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (done !== '1) fail_now("global_timeout", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
